// File: rtl/nroot_param.sv
// ---------------------------------------------------------------------------
// nroot_param : multi-cycle restoring integer square / cube root with remainder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nroot_param #(
  parameter int WIDTH  = 8,
  parameter int ROOT_W = (WIDTH + 1) / 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [WIDTH-1:0]  a_bi,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROOT_W-1:0] y_bo,
  output logic [WIDTH-1:0]  rem_bo
);

  localparam int N_SQ = (WIDTH + 1) / 2;
  localparam int N_CB = (WIDTH + 2) / 3;
  localparam int BW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(N_SQ + 1);
  localparam int SW   = $clog2(3 * N_SQ + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SQ_ITER = 3'd1;
  localparam logic [2:0] ST_CB_MUL  = 3'd2;
  localparam logic [2:0] ST_CB_SUB  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        r_state, w_state_nx;
  logic [WIDTH-1:0]  r_x, r_rem;
  logic [ROOT_W-1:0] r_y, r_yo;
  logic [BW-1:0]     r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_mode;

  logic [SW-1:0]     w_sh;
  logic [BW-1:0]     w_xe, w_ye, w_y2e, w_sq_b, w_cb_b;
  logic              w_sq_ge, w_cb_ge, w_last;
  logic [WIDTH-1:0]  w_sq_x, w_cb_x;
  logic [ROOT_W-1:0] w_sq_y, w_cb_y;

  // Trial values are formed at full width so an oversized b never wraps below x.
  assign w_sh    = r_mode ? SW'(r_cnt) * SW'(3) : SW'(r_cnt) * SW'(2);
  assign w_xe    = BW'(r_x);
  assign w_ye    = BW'(r_y);
  assign w_y2e   = w_ye << 1;
  assign w_sq_b  = ((w_ye << 2) | BW'(1)) << w_sh;
  assign w_cb_b  = ((BW'(3) * w_y2e * (w_y2e + BW'(1))) + BW'(1)) << w_sh;
  assign w_sq_ge = (w_xe >= w_sq_b);
  assign w_cb_ge = (w_xe >= r_b);
  assign w_last  = (r_cnt == '0);
  assign w_sq_x  = w_sq_ge ? (r_x - w_sq_b[WIDTH-1:0]) : r_x;
  assign w_sq_y  = (r_y << 1) | ROOT_W'(w_sq_ge);
  assign w_cb_x  = w_cb_ge ? (r_x - r_b[WIDTH-1:0]) : r_x;
  assign w_cb_y  = r_y + ROOT_W'(w_cb_ge);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) w_state_nx = mode_i ? ST_CB_MUL : ST_SQ_ITER;
        else         w_state_nx = ST_IDLE;
      end
      ST_SQ_ITER: w_state_nx = w_last ? ST_DONE : ST_SQ_ITER;
      ST_CB_MUL:  w_state_nx = ST_CB_SUB;
      ST_CB_SUB:  w_state_nx = w_last ? ST_DONE : ST_CB_MUL;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == ST_SQ_ITER) || (r_state == ST_CB_MUL) || (r_state == ST_CB_SUB);
    done_o = (r_state == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x    <= '0;
      r_y    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_yo   <= '0;
      r_rem  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_x    <= a_bi;
            r_mode <= mode_i;
            r_y    <= '0;
            r_b    <= '0;
            r_cnt  <= mode_i ? CW'(N_CB - 1) : CW'(N_SQ - 1);
          end
        end
        ST_SQ_ITER: begin
          r_x <= w_sq_x;
          r_y <= w_sq_y;
          if (w_last) begin
            r_yo  <= w_sq_y;
            r_rem <= w_sq_x;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_CB_MUL: begin
          r_y <= r_y << 1;
          r_b <= w_cb_b;
        end
        ST_CB_SUB: begin
          r_x <= w_cb_x;
          r_y <= w_cb_y;
          if (w_last) begin
            r_yo  <= w_cb_y;
            r_rem <= w_cb_x;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign y_bo   = r_yo;
  assign rem_bo = r_rem;

endmodule

`default_nettype wire
